regfile_rn: RTL and testbench
=============================

# regfile_rn

Parametrised renaming architectural register file for the out-of-order core. It holds committed register values together with a per-register busy bit and rename tag (ROB index). It accepts several dispatch (rename) and ROB-commit channels per cycle, and serves several operand read ports with same-cycle commit bypass. It also supports pipeline-flush recovery and exports a registered count of in-flight (busy) registers to dispatch-stall logic.

## Interface
- WIDTH, 32, data width in bits.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- TAG_W, 4, ROB tag width; must satisfy TAG_W <= WIDTH.
- NRD, 2, number of operand read ports.
- NDISP, 1, number of dispatch (rename) ports per cycle.
- NCOMMIT, 1, number of ROB commit channels per cycle.

Let AW = $clog2(NREG).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush; discards all outstanding renames.
- commit_valid  in  NCOMMIT  per-channel commit strobe.
- commit_tag  in  NCOMMIT x TAG_W  ROB tag being committed.
- commit_data  in  NCOMMIT x WIDTH  committed result value.
- disp_valid  in  NDISP  per-port rename strobe.
- disp_rd  in  NDISP x AW  destination register.
- disp_tag  in  NDISP x TAG_W  ROB tag allocated to the destination.
- rd_addr  in  NRD x AW  operand register address.
- rd_busy  out  NRD  operand still pending; rd_val holds a tag.
- rd_val  out  NRD x WIDTH  operand value, or zero-extended tag when rd_busy=1.
- busy_count  out  AW+1  registered count of registers with busy=1.

## Operation
- Per-register state: data[WIDTH], busy, tag[TAG_W]. Register 0 is never busy, never written, and always reads data 0 with busy 0.
- **Commit.** For every register i != 0 with busy=1, find the lowest-index channel c with commit_valid[c] and commit_tag[c]==tag[i]. If one exists: data[i] <= commit_data[c], busy[i] <= 0. A register whose tag does not match is left untouched; that case means it has been renamed by a younger instruction.
- **Dispatch.** For each p with disp_valid[p] and disp_rd[p] != 0: busy <= 1, tag <= disp_tag[p]. When several ports name the same rd, the highest index p wins.
- **Commit and dispatch on the same register, same cycle.**
  - data takes the commit value.
  - busy = 1 and tag = the dispatch tag, because dispatch overrides.
- **Flush.** All busy bits are cleared to 0 and tags are left unchanged.
  - Commits in the same cycle still write data.
  - Dispatches in the same cycle are discarded, because flush beats dispatch.
- **Read (combinational).**
  - Register not busy: rd_busy=0, rd_val=data.
  - Register busy, and some valid commit channel has a tag equal to its tag this cycle: rd_busy=0, rd_val=that commit_data (bypass; lowest channel wins).
  - Otherwise: rd_busy=1, rd_val={zeros, tag}.
  - Reads never observe same-cycle dispatches or flush. Intra-group renaming is the dispatch stage's job.
- **busy_count.** Registered population count of the busy bits after each update. Range 0..NREG-1.

## Timing
- Reset, one cycle with rst=1:
  - every data, busy and tag = 0;
  - busy_count = 0;
  - rd_busy = 0 and rd_val = 0 for all ports from the next cycle on.
- rst takes priority over flush, commit and dispatch.
- Read path has zero latency: outputs follow rd_addr and commit inputs within the same cycle.
- State updates from commit, dispatch and flush become visible to reads on the cycle after the clock edge.
- busy_count reflects the state as of the last edge (1-cycle latency).
- A commit whose tag matches no busy register has no effect.
- Duplicate tags on multiple commit channels in one cycle are resolved by the lowest channel.
- rst asserted mid-operation discards all pending renames.

## Test plan
- **Reset.** Run rst for 1 cycle, then read r0–r31 through every port. Required: rd_busy=0 and rd_val=0 everywhere; busy_count=0.
- **Rename then commit.**
  - Cycle 0: dispatch r5 with tag 3. Cycle 1: read r5. Required: rd_busy=1, rd_val=3; busy_count=1.
  - Cycle 1: commit tag 3 with data 0xDEADBEEF. Required: same-cycle read of r5 returns busy=0, 0xDEADBEEF; the next cycle returns the same value from the stored data.
- **WAW stale commit.** Dispatch r7 with tag 2, then r7 with tag 6, then commit tag 2 with 0x11. Required: r7 stays busy with tag 6. A later commit of tag 6 with 0x22 leaves r7 = 0x22, not busy.
- **Simultaneous commit and dispatch on one register.** r9 is busy with tag 1. In one cycle, commit tag 1 with 0x55 and dispatch r9 with tag 4. Required next cycle: r9 busy, tag 4; after a later commit of tag 4 with 0x66, r9 reads 0x66.
- **Flush.** r3 (tag 1) and r4 (tag 2) are busy. Assert flush together with a dispatch of r6 (tag 5) and a commit of tag 1 with 0x77. Required next cycle:
  - r3 = 0x77, not busy;
  - r4 not busy, holding its old data;
  - r6 not busy;
  - busy_count=0.
- **Register 0 and port conflicts.**
  - Dispatch r0 with tag 7. Required: r0 still reads 0, not busy.
  - With NDISP=2, dispatch r8 with tag 1 on port 0 and tag 2 on port 1. Required: r8 is busy with tag 2.

Source files
------------

// File: rtl/regfile_rn.sv
// regfile_rn: renaming architectural register file.
// Each register holds committed data, a busy bit and the ROB tag of the newest
// in-flight writer. Register 0 is hardwired to zero and never busy.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all outstanding renames (clears busy bits)
//   commit_*          NCOMMIT ROB commit channels (valid, tag, data)
//   disp_*            NDISP rename ports (valid, destination, tag)
//   rd_addr           NRD operand read addresses
//   rd_busy, rd_val   combinational operand result (value, or tag when busy)
//   busy_count        registered population count of busy registers
module regfile_rn #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned NRD     = 2,
    parameter int unsigned NDISP   = 1,
    parameter int unsigned NCOMMIT = 1,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NCOMMIT-1:0]         commit_valid,
    input  logic [NCOMMIT*TAG_W-1:0]   commit_tag,
    input  logic [NCOMMIT*WIDTH-1:0]   commit_data,
    input  logic [NDISP-1:0]           disp_valid,
    input  logic [NDISP*AW-1:0]        disp_rd,
    input  logic [NDISP*TAG_W-1:0]     disp_tag,
    input  logic [NRD*AW-1:0]          rd_addr,
    output logic [NRD-1:0]             rd_busy,
    output logic [NRD*WIDTH-1:0]       rd_val,
    output logic [AW:0]                busy_count
);

    logic [WIDTH-1:0] data_q [NREG];
    logic [WIDTH-1:0] data_d [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    // Per-register commit match; shared by the update and read bypass paths.
    logic [NREG-1:0]  cm_hit;
    logic [WIDTH-1:0] cm_data [NREG];

    // Scan channels high to low so the lowest matching channel wins.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            cm_hit[i]  = 1'b0;
            cm_data[i] = '0;
            for (int c = int'(NCOMMIT) - 1; c >= 0; c--) begin
                if (commit_valid[c] && (commit_tag[c*TAG_W +: TAG_W] == tag_q[i])) begin
                    cm_hit[i]  = busy_q[i];
                    cm_data[i] = commit_data[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next-state: commit first, then flush or dispatch (dispatch overrides busy/tag).
    always_comb begin
        data_d       = data_q;
        tag_d        = tag_q;
        busy_d       = busy_q;
        busy_count_d = '0;

        for (int unsigned i = 1; i < NREG; i++) begin
            if (cm_hit[i]) begin
                data_d[i] = cm_data[i];
                busy_d[i] = 1'b0;
            end
        end

        if (flush) begin
            busy_d = '0;
        end else begin
            // Ascending port order: the highest port naming a register wins.
            for (int unsigned p = 0; p < NDISP; p++) begin
                if (disp_valid[p] && (disp_rd[p*AW +: AW] != '0)
                    && (32'(disp_rd[p*AW +: AW]) < NREG)) begin
                    busy_d[disp_rd[p*AW +: AW]] = 1'b1;
                    tag_d[disp_rd[p*AW +: AW]]  = disp_tag[p*TAG_W +: TAG_W];
                end
            end
        end

        busy_d[0] = 1'b0;

        for (int unsigned i = 0; i < NREG; i++) begin
            busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            for (int unsigned i = 0; i < NREG; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    // Operand read with same-cycle commit bypass; out-of-range addresses read zero.
    always_comb begin
        rd_busy = '0;
        rd_val  = '0;
        for (int unsigned r = 0; r < NRD; r++) begin
            if (32'(rd_addr[r*AW +: AW]) < NREG) begin
                if (!busy_q[rd_addr[r*AW +: AW]]) begin
                    rd_val[r*WIDTH +: WIDTH] = data_q[rd_addr[r*AW +: AW]];
                end else if (cm_hit[rd_addr[r*AW +: AW]]) begin
                    rd_val[r*WIDTH +: WIDTH] = cm_data[rd_addr[r*AW +: AW]];
                end else begin
                    rd_busy[r]               = 1'b1;
                    rd_val[r*WIDTH +: WIDTH] = WIDTH'(tag_q[rd_addr[r*AW +: AW]]);
                end
            end
        end
    end

    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_rn.sv
// tb_regfile_rn: directed self-checking bench for regfile_rn
// (NRD=2, NDISP=2, NCOMMIT=2). Inputs change 1 time unit after the rising
// edge; outputs are sampled 1 time unit after each input change.
module tb_regfile_rn;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NREG    = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned NRD     = 2;
    localparam int unsigned NDISP   = 2;
    localparam int unsigned NCOMMIT = 2;
    localparam int unsigned AW      = 5;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NCOMMIT-1:0]       commit_valid;
    logic [NCOMMIT*TAG_W-1:0] commit_tag;
    logic [NCOMMIT*WIDTH-1:0] commit_data;
    logic [NDISP-1:0]         disp_valid;
    logic [NDISP*AW-1:0]      disp_rd;
    logic [NDISP*TAG_W-1:0]   disp_tag;
    logic [NRD*AW-1:0]        rd_addr;
    logic [NRD-1:0]           rd_busy;
    logic [NRD*WIDTH-1:0]     rd_val;
    logic [AW:0]              busy_count;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_rn #(
        .WIDTH(WIDTH), .NREG(NREG), .TAG_W(TAG_W),
        .NRD(NRD), .NDISP(NDISP), .NCOMMIT(NCOMMIT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_data(commit_data),
        .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
        .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_val(rd_val),
        .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush        = 1'b0;
        commit_valid = '0;
        commit_tag   = '0;
        commit_data  = '0;
        disp_valid   = '0;
        disp_rd      = '0;
        disp_tag     = '0;
    endtask

    task automatic disp(input int p, input logic [AW-1:0] rd, input logic [TAG_W-1:0] tag);
        disp_valid[p]            = 1'b1;
        disp_rd[p*AW +: AW]      = rd;
        disp_tag[p*TAG_W +: TAG_W] = tag;
    endtask

    task automatic commit(input int c, input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] data);
        commit_valid[c]              = 1'b1;
        commit_tag[c*TAG_W +: TAG_W] = tag;
        commit_data[c*WIDTH +: WIDTH] = data;
    endtask

    task automatic chk_rd(input string name, input int port, input logic [AW-1:0] addr,
                          input logic ebusy, input logic [WIDTH-1:0] eval);
        rd_addr[port*AW +: AW] = addr;
        #1;
        check({name, "_busy"}, 64'(rd_busy[port]), 64'(ebusy));
        check({name, "_val"},  64'(rd_val[port*WIDTH +: WIDTH]), 64'(eval));
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        clear_inputs();
        tick();
        rst = 1'b0;

        // Reset state on every register and port.
        check("rst_count", 64'(busy_count), 64'd0);
        for (int r = 0; r < 32; r++) begin
            chk_rd("rst_p0", 0, AW'(r), 1'b0, 32'h0);
            chk_rd("rst_p1", 1, AW'(r), 1'b0, 32'h0);
        end

        // Rename r5 then commit with same-cycle bypass.
        tick();
        disp(0, 5'd5, 4'd3);
        tick();
        clear_inputs();
        chk_rd("ren_pend", 0, 5'd5, 1'b1, 32'd3);
        check("ren_count1", 64'(busy_count), 64'd1);
        commit(0, 4'd3, 32'hDEADBEEF);
        chk_rd("ren_bypass", 1, 5'd5, 1'b0, 32'hDEADBEEF);
        tick();
        clear_inputs();
        chk_rd("ren_stored", 0, 5'd5, 1'b0, 32'hDEADBEEF);
        check("ren_count0", 64'(busy_count), 64'd0);

        // WAW: stale commit of the older tag must not retire r7.
        disp(0, 5'd7, 4'd2);
        tick();
        disp(0, 5'd7, 4'd6);
        tick();
        clear_inputs();
        commit(0, 4'd2, 32'h11);
        chk_rd("waw_same", 0, 5'd7, 1'b1, 32'd6);
        tick();
        clear_inputs();
        chk_rd("waw_stale", 0, 5'd7, 1'b1, 32'd6);
        commit(1, 4'd6, 32'h22);
        tick();
        clear_inputs();
        chk_rd("waw_done", 1, 5'd7, 1'b0, 32'h22);

        // Commit and re-dispatch of r9 in one cycle.
        disp(0, 5'd9, 4'd1);
        tick();
        commit(0, 4'd1, 32'h55);
        disp(0, 5'd9, 4'd4);
        tick();
        clear_inputs();
        chk_rd("cd_pend", 0, 5'd9, 1'b1, 32'd4);
        check("cd_count1", 64'(busy_count), 64'd1);
        commit(0, 4'd4, 32'h66);
        tick();
        clear_inputs();
        chk_rd("cd_done", 0, 5'd9, 1'b0, 32'h66);

        // Commit of a tag owned by no busy register is ignored.
        commit(0, 4'd9, 32'h99);
        tick();
        clear_inputs();
        chk_rd("nomatch", 1, 5'd9, 1'b0, 32'h66);

        // Flush with a concurrent dispatch and commit.
        disp(0, 5'd4, 4'd2);
        tick();
        commit(0, 4'd2, 32'h44);
        tick();
        clear_inputs();
        disp(0, 5'd3, 4'd1);
        disp(1, 5'd4, 4'd2);
        tick();
        clear_inputs();
        check("fl_count2", 64'(busy_count), 64'd2);
        flush = 1'b1;
        disp(0, 5'd6, 4'd5);
        commit(0, 4'd1, 32'h77);
        tick();
        clear_inputs();
        chk_rd("fl_r3", 0, 5'd3, 1'b0, 32'h77);
        chk_rd("fl_r4", 1, 5'd4, 1'b0, 32'h44);
        chk_rd("fl_r6", 0, 5'd6, 1'b0, 32'h0);
        check("fl_count0", 64'(busy_count), 64'd0);

        // Register 0 ignores dispatch.
        disp(0, 5'd0, 4'd7);
        tick();
        clear_inputs();
        chk_rd("r0_disp", 0, 5'd0, 1'b0, 32'h0);
        check("r0_count", 64'(busy_count), 64'd0);

        // Same-rd dispatch on two ports: highest port wins.
        disp(0, 5'd8, 4'd1);
        disp(1, 5'd8, 4'd2);
        tick();
        clear_inputs();
        chk_rd("pc_tag", 1, 5'd8, 1'b1, 32'd2);
        check("pc_count", 64'(busy_count), 64'd1);

        // Duplicate commit tag on both channels: lowest channel wins.
        commit(0, 4'd2, 32'hAAAA);
        commit(1, 4'd2, 32'hBBBB);
        chk_rd("dup_bypass", 0, 5'd8, 1'b0, 32'hAAAA);
        tick();
        clear_inputs();
        chk_rd("dup_stored", 1, 5'd8, 1'b0, 32'hAAAA);

        // Mid-operation reset discards pending renames and data.
        disp(0, 5'd10, 4'd3);
        tick();
        clear_inputs();
        check("mr_count1", 64'(busy_count), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_rd("mr_r10", 0, 5'd10, 1'b0, 32'h0);
        chk_rd("mr_r8", 1, 5'd8, 1'b0, 32'h0);
        check("mr_count0", 64'(busy_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
